// File: rtl/spi_master_ctrl.sv
// -----------------------------------------------------------------------------
// spi_master_ctrl
// SPI master, mode 0 (CPOL=0, CPHA=0), MSB first. Each accepted start sends
// one command byte followed by `len` payload bytes pulled from a valid/ready
// port. The byte clocked in during the command phase lands in id_byte; every
// payload byte clocked in is presented on rx_data with a one-cycle rx_valid.
//
// Parameters
//   CLK_DIV  clk cycles per SCK half-period (>= 2)
//   CS_GAP   clk cycles of chip-select guard time (>= 1)
// Ports
//   clk, rst_n           system clock, asynchronous active-low reset
//   start, cmd, len      transaction request, captured in IDLE
//   busy, done           transaction in progress / end-of-transaction pulse
//   tx_data/valid/ready  payload byte source (transfer on valid & ready)
//   rx_data, rx_valid    received payload byte and its strobe
//   id_byte              byte received during the command phase
//   ncs_spi, sck_spi,
//   mosi_spi, miso_spi   SPI pins
// -----------------------------------------------------------------------------
module spi_master_ctrl #(
   parameter int unsigned CLK_DIV = 4,
   parameter int unsigned CS_GAP  = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic [7:0] cmd,
   input  logic [9:0] len,
   output logic       busy,
   output logic       done,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic [7:0] id_byte,
   output logic       ncs_spi,
   output logic       sck_spi,
   output logic       mosi_spi,
   input  logic       miso_spi
);

   typedef enum logic [2:0] {IDLE, SETUP, SHIFT, LOAD, HOLD, GAP} state_t;

   localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);
   localparam logic [15:0] GAP_LAST = 16'(CS_GAP - 1);

   state_t      state;
   logic [15:0] cnt;      // cycle counter for guard times and SCK half-periods
   logic [2:0]  bit_cnt;  // bits completed in the current byte
   logic [9:0]  remain;   // payload bytes still to be loaded
   logic [7:0]  tx_sr;
   logic [7:0]  rx_sr;
   logic        is_cmd;   // current byte is the command byte
   logic        rx_pend;  // full byte sitting in rx_sr, publish next cycle

   // NOTE: every register here is state, so all assignments are non-blocking;
   // blocking assignments would make the result depend on statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         cnt      <= '0;
         bit_cnt  <= '0;
         remain   <= '0;
         tx_sr    <= '0;
         rx_sr    <= '0;
         is_cmd   <= 1'b0;
         rx_pend  <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         tx_ready <= 1'b0;
         rx_data  <= '0;
         rx_valid <= 1'b0;
         id_byte  <= '0;
         ncs_spi  <= 1'b1;
         sck_spi  <= 1'b0;
         mosi_spi <= 1'b0;
      end else begin
         done     <= 1'b0;
         rx_valid <= 1'b0;

         // Publish a completed byte one cycle after its last bit was sampled.
         // With CLK_DIV >= 2 this always happens inside bit0's high phase,
         // before is_cmd is cleared at the end of the byte.
         if (rx_pend) begin
            rx_pend <= 1'b0;
            if (is_cmd) begin
               id_byte <= rx_sr;
            end else begin
               rx_data  <= rx_sr;
               rx_valid <= 1'b1;
            end
         end

         case (state)
            IDLE: begin
               if (start) begin
                  state    <= SETUP;
                  busy     <= 1'b1;
                  ncs_spi  <= 1'b0;
                  cnt      <= '0;
                  bit_cnt  <= '0;
                  remain   <= len;
                  tx_sr    <= cmd;
                  mosi_spi <= cmd[7];
                  is_cmd   <= 1'b1;
               end
            end

            SETUP: begin
               if (cnt == GAP_LAST) begin
                  cnt   <= '0;
                  state <= SHIFT;
               end else begin
                  cnt <= cnt + 16'd1;
               end
            end

            SHIFT: begin
               if (cnt == DIV_LAST) begin
                  cnt <= '0;
                  if (!sck_spi) begin
                     // Rising edge: slave data has been stable for the whole low phase.
                     sck_spi <= 1'b1;
                     rx_sr   <= {rx_sr[6:0], miso_spi};
                     if (bit_cnt == 3'd7) rx_pend <= 1'b1;
                  end else begin
                     sck_spi <= 1'b0;
                     if (bit_cnt == 3'd7) begin
                        bit_cnt <= '0;
                        is_cmd  <= 1'b0;
                        if (remain != '0) begin
                           state    <= LOAD;
                           tx_ready <= 1'b1;
                        end else begin
                           state <= HOLD;
                        end
                     end else begin
                        bit_cnt  <= bit_cnt + 3'd1;
                        tx_sr    <= {tx_sr[6:0], 1'b0};
                        mosi_spi <= tx_sr[6];
                     end
                  end
               end else begin
                  cnt <= cnt + 16'd1;
               end
            end

            LOAD: begin
               if (tx_valid && tx_ready) begin
                  tx_ready <= 1'b0;
                  tx_sr    <= tx_data;
                  mosi_spi <= tx_data[7];
                  remain   <= remain - 10'd1;
                  state    <= SHIFT;
               end
            end

            HOLD: begin
               if (cnt == GAP_LAST) begin
                  cnt     <= '0;
                  state   <= GAP;
                  ncs_spi <= 1'b1;
                  done    <= 1'b1;
               end else begin
                  cnt <= cnt + 16'd1;
               end
            end

            GAP: begin
               if (cnt == GAP_LAST) begin
                  cnt   <= '0;
                  state <= IDLE;
                  busy  <= 1'b0;
               end else begin
                  cnt <= cnt + 16'd1;
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule
